// File: rtl/pu_or1k_pkg.sv
// Shared types and helpers for the cappuccino pipelined multiplier.
package pu_or1k_pkg;

  localparam int MUL_LATENCY = 3;
  localparam int MUL_MAX_W   = 64;
  // Partial products are kept sign-extended to a fixed width so the struct
  // does not depend on the multiplier's operand width parameter.
  localparam int MUL_PP_W    = 2 * MUL_MAX_W;

  typedef struct packed {
    logic [MUL_PP_W-1:0] hh;
    logic [MUL_PP_W-1:0] hl;
    logic [MUL_PP_W-1:0] lh;
    logic [MUL_PP_W-1:0] ll;
  } mul_pp_t;

  // {ov, cy}: ov when the signed product does not fit in w bits,
  // cy when the unsigned product has any bit set above w.
  function automatic logic [1:0] mul_flags(input logic [MUL_PP_W-1:0] p,
                                           input int w, input logic sgn);
    logic ov_dif;
    logic cy_any;
    ov_dif = 1'b0;
    cy_any = 1'b0;
    for (int i = 0; i < MUL_PP_W; i++) begin
      if (i >= w - 1 && i < 2 * w && p[i] != p[2*w-1]) ov_dif = 1'b1;
      if (i >= w && i < 2 * w && p[i]) cy_any = 1'b1;
    end
    return {sgn & ov_dif, ~sgn & cy_any};
  endfunction

endpackage

// File: rtl/pu_or1k_mul_pp.sv
// Half-width partial-product generator on (W+1)-bit extended operands.
module pu_or1k_mul_pp
  import pu_or1k_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W:0] a_i,
  input  logic [W:0] b_i,
  output mul_pp_t    pp_o
);

  localparam int HW = W / 2;

  // Upper halves carry the extension bit and are treated as signed; this is
  // where the signed correction comes in. Lower halves are plain unsigned.
  logic signed [W+1:0] ahs, bhs, als, bls;
  logic signed [W+1:0] hh, hl, lh, ll;

  assign ahs = (W+2)'($signed(a_i[W:HW]));
  assign bhs = (W+2)'($signed(b_i[W:HW]));
  assign als = (W+2)'(a_i[HW-1:0]);
  assign bls = (W+2)'(b_i[HW-1:0]);

  assign hh = ahs * bhs;
  assign hl = ahs * bls;
  assign lh = als * bhs;
  assign ll = als * bls;

  assign pp_o.hh = MUL_PP_W'(hh);
  assign pp_o.hl = MUL_PP_W'(hl);
  assign pp_o.lh = MUL_PP_W'(lh);
  assign pp_o.ll = MUL_PP_W'(ll);

endmodule

// File: rtl/pu_or1k_mul_pipe_cappuccino.sv
// 3-cycle pipelined l.mul/l.mulu unit with busy handshake and ov/cy flags.
// Define PU_OR1K_MUL_WIDE_EN to register and expose the high product word.
module pu_or1k_mul_pipe_cappuccino
  import pu_or1k_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32  // even, at most MUL_MAX_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_execute_i,
  input  logic                            pipeline_flush_i,
  input  logic                            op_mul_i,
  input  logic                            op_mul_signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rfa_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rfb_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] mul_result_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mul_result_hi_o,
  output logic                            mul_valid_o,
  output logic                            mul_busy_o,
  output logic                            mul_ov_o,
  output logic                            mul_cy_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int HW = W / 2;

  logic [MUL_LATENCY:1] vld_q, vld_d;
  logic                 accept;
  logic [W:0]           a_q, b_q, a_d, b_d;
  logic                 sgn1_q, sgn2_q;
  mul_pp_t              pp_d, pp_q;
  logic [MUL_PP_W-1:0]  sum;
  logic [1:0]           flags;
  logic [W-1:0]         res_q;
  logic                 ov_q, cy_q;

  assign mul_busy_o = vld_q[1] | vld_q[2];
  assign accept     = op_mul_i & padv_execute_i & ~mul_busy_o & ~pipeline_flush_i;
  assign vld_d      = {vld_q[MUL_LATENCY-1:1], accept} & {MUL_LATENCY{~pipeline_flush_i}};

  assign a_d = op_mul_signed_i ? {rfa_i[W-1], rfa_i} : {1'b0, rfa_i};
  assign b_d = op_mul_signed_i ? {rfb_i[W-1], rfb_i} : {1'b0, rfb_i};

  pu_or1k_mul_pp #(.W(W)) u_pp (
    .a_i  (a_q),
    .b_i  (b_q),
    .pp_o (pp_d)
  );

  // Modulo arithmetic at MUL_PP_W bits; only the low 2W bits are meaningful.
  assign sum   = (pp_q.hh << W) + ((pp_q.hl + pp_q.lh) << HW) + pp_q.ll;
  assign flags = mul_flags(sum, W, sgn2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn1_q <= 1'b0;
      sgn2_q <= 1'b0;
      pp_q   <= '0;
      res_q  <= '0;
      ov_q   <= 1'b0;
      cy_q   <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (accept) begin
        a_q    <= a_d;
        b_q    <= b_d;
        sgn1_q <= op_mul_signed_i;
      end
      if (vld_q[1]) begin
        pp_q   <= pp_d;
        sgn2_q <= sgn1_q;
      end
      // Result and flags hold after valid drops; writeback samples them late.
      if (vld_q[2] && !pipeline_flush_i) begin
        res_q <= sum[W-1:0];
        ov_q  <= flags[1];
        cy_q  <= flags[0];
      end
    end
  end

`ifdef PU_OR1K_MUL_WIDE_EN
  logic [W-1:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                hi_q <= '0;
    else if (vld_q[2] && !pipeline_flush_i) hi_q <= sum[2*W-1:W];
  end

  assign mul_result_hi_o = hi_q;
`else
  assign mul_result_hi_o = '0;
`endif

  assign mul_result_o = res_q;
  assign mul_valid_o  = vld_q[MUL_LATENCY];
  assign mul_ov_o     = ov_q;
  assign mul_cy_o     = cy_q;

endmodule

// File: tb/tb_pu_or1k_mul_pipe_cappuccino.sv
// Table-driven bench with a scoreboard for the pipelined multiplier.
module tb_pu_or1k_mul_pipe_cappuccino;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, lo, hi;
    logic        ov, cy;
  } vec_t;

  typedef struct {
    logic [31:0] lo, hi;
    logic        ov, cy;
    int          cyc;
  } exp_t;

  logic        clk, rst, padv, flush, op, sgn;
  logic [31:0] a, b, res, res_hi;
  logic        valid, busy, ov, cy;

  int   checks = 0, failures = 0, cyc = 0;
  exp_t sb[$];
  vec_t vecs[12];

  pu_or1k_mul_pipe_cappuccino #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .padv_execute_i   (padv),
    .pipeline_flush_i (flush),
    .op_mul_i         (op),
    .op_mul_signed_i  (sgn),
    .rfa_i            (a),
    .rfb_i            (b),
    .mul_result_o     (res),
    .mul_result_hi_o  (res_hi),
    .mul_valid_o      (valid),
    .mul_busy_o       (busy),
    .mul_ov_o         (ov),
    .mul_cy_o         (cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
    vec_t   v;
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) p = 64'(sx * sy);
    else   p = {32'b0, x} * {32'b0, y};
    v.sgn = s; v.a = x; v.b = y;
    v.lo  = p[31:0];
    v.hi  = p[63:32];
    v.ov  = s && !(p[63:31] == '0 || p[63:31] == '1);
    v.cy  = !s && (p[63:32] != 32'd0);
    return v;
  endfunction

  // Expected result for an op driven now, accepted at the coming edge.
  task automatic push(input vec_t v, input int lat);
    exp_t e;
    e.lo = v.lo; e.hi = v.hi; e.ov = v.ov; e.cy = v.cy;
    e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    op = 1'b1; padv = 1'b1; sgn = s; a = x; b = y;
    tick();
    op = 1'b0; padv = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      chk("scoreboard_drain", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("result", 64'(res), 64'(e.lo));
        chk("ov", 64'(ov), 64'(e.ov));
        chk("cy", 64'(cy), 64'(e.cy));
`ifdef PU_OR1K_MUL_WIDE_EN
        chk("result_hi", 64'(res_hi), 64'(e.hi));
`else
        chk("result_hi_zero", 64'(res_hi), 64'd0);
`endif
      end
    end
  end

  initial begin
    int t0;
    vec_t v;
    vecs[0]  = '{1'b0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h40000000, 32'h00000002, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h12345678, 32'h00000002, 32'h2468ACF0, 32'h00000000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1};

    rst = 1'b1; padv = 1'b0; flush = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("reset_ctrl", {60'd0, valid, busy, ov, cy}, 64'd0);
    chk("reset_result", 64'(res), 64'd0);
    chk("reset_result_hi", 64'(res_hi), 64'd0);
    rst = 1'b0;
    tick();

    // No accept without execute advancing.
    op = 1'b1; sgn = 1'b0; a = 32'd3; b = 32'd3;
    tick();
    op = 1'b0;
    chk("no_accept_without_padv", 64'(busy), 64'd0);
    tick(); tick(); tick();

    for (int i = 0; i < 12; i++) begin
      push(vecs[i], 3);
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_idle();
    end

    // Result/flags held two cycles after valid dropped.
    tick(); tick();
    chk("hold_result", 64'(res), 64'hFFFFFFFE);
    chk("hold_cy", 64'(cy), 64'd1);
    chk("hold_valid_low", 64'(valid), 64'd0);

    for (int i = 0; i < 8; i++) begin
      v = model(1'($urandom_range(0, 1)), $urandom, $urandom);
      push(v, 3);
      issue(v.sgn, v.a, v.b);
      wait_idle();
    end

    // Busy blocking: op held high, second accept only at t+3.
    t0 = cyc;
    op = 1'b1; padv = 1'b1; sgn = 1'b0; a = 32'd3; b = 32'd5;
    push(model(1'b0, 32'd3, 32'd5), 3);
    tick();
    chk("busy_t1", 64'(busy), 64'd1);
    a = 32'd7; b = 32'd9;
    v = model(1'b0, 32'd7, 32'd9);
    push(v, 5);
    tick();
    chk("busy_t2", 64'(busy), 64'd1);
    tick();
    chk("busy_t3", 64'(busy), 64'd0);
    chk("busy_seq_t3_cycle", 64'(cyc - t0), 64'd3);
    tick();
    op = 1'b0; padv = 1'b0;
    wait_idle();
    chk("b2b_result", 64'(res), 64'd63);

    // Flush one cycle after accept: no valid, busy drops, result kept.
    issue(1'b1, 32'd5, 32'd6);
    flush = 1'b1;
    chk("flush_busy_t1", 64'(busy), 64'd1);
    tick();
    flush = 1'b0;
    chk("flush_busy_t2", 64'(busy), 64'd0);
    tick(); tick(); tick();
    chk("flush_result_kept", 64'(res), 64'd63);

    // Flush and accept together: nothing accepted.
    op = 1'b1; padv = 1'b1; flush = 1'b1; a = 32'd2; b = 32'd2;
    tick();
    op = 1'b0; padv = 1'b0; flush = 1'b0;
    chk("flush_accept_same_cycle", 64'(busy), 64'd0);
    tick(); tick(); tick();

    // Asynchronous reset mid-operation.
    issue(1'b0, 32'd2, 32'd3);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {60'd0, valid, busy, ov, cy}, 64'd0);
    chk("async_rst_result", 64'(res), 64'd0);
    #3 rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("post_rst_idle", {62'd0, valid, busy}, 64'd0);

    v = model(1'b1, 32'hFFFFFFFB, 32'd4);
    push(v, 3);
    issue(v.sgn, v.a, v.b);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
